// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: tick-paced UART transmit sequencer (start, 5-8 data bits LSB-first, optional parity, 1-2 stops)
// that owns the baud divisor and only updates it while the line is idle.
module uart_tx_ctrl #(
  parameter int UBRR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [UBRR_W-1:0] ubrr_in,
  output logic [UBRR_W-1:0] ubrr_out,
  input  logic              tick,
  input  logic [1:0]        cfg_dbits,
  input  logic [1:0]        cfg_par,
  input  logic              cfg_stop,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, ns;
  logic [7:0]        sh, sh_n;
  logic [2:0]        cnt, cnt_n;
  logic              acc, acc_n;
  logic [1:0]        len_q, len_n, par_q, par_n;
  logic              stop_q, stop_n;
  logic              txd_n, done_n;
  logic [UBRR_W-1:0] ubrr_n;
  logic              accept, par_en, last, shift;
  assign accept = state == IDLE && tx_valid;
  assign par_en = par_q == 2'b01 || par_q == 2'b10;
  assign last   = cnt == {1'b0, len_q} + 3'd4;
  assign shift  = state == DATA && tick;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      len_q    <= '0;
      par_q    <= '0;
      stop_q   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      ubrr_out <= '0;
    end else begin
      state    <= ns;
      sh       <= sh_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      len_q    <= len_n;
      par_q    <= par_n;
      stop_q   <= stop_n;
      txd      <= txd_n;
      tx_ready <= ns == IDLE;
      tx_busy  <= ns != IDLE;
      tx_done  <= done_n;
      ubrr_out <= ubrr_n;
    end
  end
  always_comb begin
    ns = state;
    unique case (state)
      IDLE:    ns = accept ? SYNC : IDLE;
      SYNC:    ns = tick ? START : SYNC;
      START:   ns = tick ? DATA : START;
      DATA:    ns = tick && last ? (par_en ? PARITY : STOP1) : DATA;
      PARITY:  ns = tick ? STOP1 : PARITY;
      STOP1:   ns = tick ? (stop_q ? STOP2 : IDLE) : STOP1;
      STOP2:   ns = tick ? IDLE : STOP2;
      default: ns = IDLE;
    endcase
  end
  // txd is derived from the next state so it only moves on tick edges
  always_comb begin
    sh_n   = accept ? tx_data : shift ? {1'b0, sh[7:1]} : sh;
    cnt_n  = accept || (state == START && tick) ? 3'd0 : shift ? cnt + 3'd1 : cnt;
    acc_n  = accept ? 1'b0 : shift ? acc ^ sh[0] : acc;
    len_n  = accept ? cfg_dbits : len_q;
    par_n  = accept ? cfg_par : par_q;
    stop_n = accept ? cfg_stop : stop_q;
    txd_n  = ns == START ? 1'b0 :
             ns == DATA ? sh_n[0] :
             ns == PARITY ? (par_q == 2'b10 ? ~acc_n : acc_n) : 1'b1;
    done_n = state != IDLE && ns == IDLE;
    ubrr_n = state == IDLE ? ubrr_in : ubrr_out;
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: random and directed frames checked cycle by cycle against a frame-level bit-list model.
module tb_uart_tx_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ubrr_in, ubrr_out;
  logic        tick;
  logic [1:0]  cfg_dbits, cfg_par;
  logic        cfg_stop;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, txd, tx_busy, tx_done;
  uart_tx_ctrl #(.UBRR_W(12)) dut (
    .clk(clk), .reset(reset), .ubrr_in(ubrr_in), .ubrr_out(ubrr_out), .tick(tick),
    .cfg_dbits(cfg_dbits), .cfg_par(cfg_par), .cfg_stop(cfg_stop), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, gcyc = 0, m_ticks = 0, m_t = 0;
  bit m_busy = 0, m_line = 1, m_done = 0;
  logic [11:0] m_ubrr = '0;
  bit m_bits[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // expected line levels after each tick: start, data LSB-first, parity, stop(s)
  function automatic void build(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pr, input logic st);
    int n;
    bit p;
    n = int'(db) + 5;
    p = 0;
    m_bits.delete();
    m_bits.push_back(0);
    for (int i = 0; i < n; i++) begin
      m_bits.push_back(d[i]);
      p ^= d[i];
    end
    if (pr == 2'b01) m_bits.push_back(p);
    else if (pr == 2'b10) m_bits.push_back(!p);
    m_bits.push_back(1);
    if (st) m_bits.push_back(1);
    m_t = m_bits.size() + 1;
  endfunction
  task automatic cyc();
    @(posedge clk);
    gcyc++;
    m_done = 0;
    if (!m_busy) begin
      m_ubrr = ubrr_in;
      if (tx_valid) begin
        build(tx_data, cfg_dbits, cfg_par, cfg_stop);
        m_busy = 1;
        m_ticks = 0;
      end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == m_t) begin
        m_busy = 0;
        m_done = 1;
        m_line = 1;
      end else m_line = m_bits[m_ticks-1];
    end
    #1;
    chk("txd", txd, m_line);
    chk("tx_done", tx_done, m_done);
    chk("tx_busy", tx_busy, m_busy);
    chk("tx_ready", tx_ready, !m_busy);
    chk("ubrr_out", ubrr_out, m_ubrr);
  endtask
  task automatic frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pr, input logic st,
                       input int per, input bit tick_acc, input logic [11:0] u0, input logic [11:0] u1);
    bit started, fin;
    started = 0;
    fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (!started) begin
        tx_valid = 1'b1;
        tx_data = d;
        cfg_dbits = db;
        cfg_par = pr;
        cfg_stop = st;
        ubrr_in = u0;
        tick = tick_acc || (gcyc % per == 0);
      end else begin
        tx_valid = 1'($urandom);
        tx_data = 8'($urandom);
        cfg_dbits = 2'($urandom);
        cfg_par = 2'($urandom);
        cfg_stop = 1'($urandom);
        ubrr_in = u1;
        tick = gcyc % per == 0;
      end
      cyc();
      if (!started && m_busy) started = 1;
      else if (started && !m_busy) fin = 1;
    end
    chk("frame_end", fin, 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b0;
      tick = 1'($urandom);
      cyc();
    end
  endtask
  task automatic rst_mid();
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    cfg_dbits = 2'b11;
    cfg_par = 2'b00;
    cfg_stop = 1'b0;
    ubrr_in = 12'd77;
    tick = 1'b0;
    cyc();
    tx_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick = gcyc % 2 == 0;
      cyc();
    end
    chk("in_frame_before_reset", tx_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ubrr", ubrr_out, 0);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_done", tx_done, 0);
      chk("rst_hold_txd", txd, 1);
      chk("rst_hold_ubrr", ubrr_out, 0);
    end
    m_busy = 0;
    m_line = 1;
    m_done = 0;
    m_ubrr = '0;
    #2 reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0;
    tick = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    cfg_dbits = '0;
    cfg_par = '0;
    cfg_stop = 1'b0;
    ubrr_in = 12'hABC;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_txd", txd, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_ubrr", ubrr_out, 0);
    #2 reset = 1'b1;
    idle(3);
    frame(8'hA5, 2'b11, 2'b00, 1'b0, 4, 0, 12'd25, 12'd25);
    idle(2);
    frame(8'hFF, 2'b10, 2'b01, 1'b1, 4, 0, 12'd40, 12'd41);
    frame(8'hFF, 2'b10, 2'b10, 1'b1, 4, 0, 12'd40, 12'd41);
    idle(1);
    frame(8'hE3, 2'b00, 2'b00, 1'b0, 3, 0, 12'd9, 12'd9);
    frame(8'h01, 2'b11, 2'b00, 1'b0, 3, 0, 12'd5, 12'd6);
    frame(8'h80, 2'b11, 2'b00, 1'b0, 3, 0, 12'd7, 12'd8);
    idle(2);
    frame(8'h55, 2'b11, 2'b00, 1'b0, 4, 0, 12'd25, 12'd103);
    idle(3);
    frame(8'hC3, 2'b11, 2'b01, 1'b0, 5, 1, 12'd11, 12'd12);
    rst_mid();
    idle(3);
    for (int f = 0; f < 40; f++) begin
      frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(1, 6),
            1'($urandom), 12'($urandom), 12'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 5));
    end
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit sequencer driven by the baud-rate generator's single-cycle `tick` strobe, one pulse per bit period.
- Accepts bytes over a valid/ready handshake and serializes them LSB-first: start bit, 5-8 data bits, optional parity, 1-2 stop bits.
- Owns the baud generator's divisor input. The divisor only changes while the line is idle, so a CPU rewrite never distorts a frame in flight.

Parameters:
UBRR_W, 12, width of the baud divisor passed to the baud-rate generator

Ports:
clk  input  1  system clock; sole clock domain
reset  input  1  asynchronous, active-low reset
ubrr_in  input  UBRR_W  CPU-requested baud divisor
ubrr_out  output  UBRR_W  divisor driven to the baud-rate generator
tick  input  1  bit-period strobe from the baud-rate generator, 1 clk wide
cfg_dbits  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits
cfg_par  input  2  parity: 00=none, 01=even, 10=odd, 11=none
cfg_stop  input  1  stop bits: 0=one, 1=two
tx_data  input  8  byte to send; bits above the data length are ignored
tx_valid  input  1  byte available
tx_ready  output  1  block can accept a byte
txd  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-clk pulse at frame end

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, txd=1, tx_ready=1, tx_busy=0, tx_done=0, ubrr_out=0.
  - Shift register, bit counter and parity accumulator are cleared.
  - Reset asserted mid-frame aborts the frame: txd returns to 1 immediately, and no tx_done is produced.
- States: IDLE, SYNC, START, DATA, PARITY, STOP1, STOP2. All outputs are registered.
- IDLE:
  - tx_ready=1, tx_busy=0, txd=1.
  - ubrr_out <= ubrr_in every clk.
  - Accept occurs when tx_valid&&tx_ready at a clk edge. On accept, latch tx_data, cfg_dbits, cfg_par and cfg_stop into internal registers, then go to SYNC.
  - Config inputs changing after accept have no effect on the current frame.
- ubrr_out is frozen in every non-IDLE state.
- tx_ready=0 and tx_busy=1 in every non-IDLE state.
- SYNC:
  - txd=1; waits for the next tick so that the start bit is a full bit period.
  - A tick coincident with the accept edge is ignored, because SYNC is only entered after that edge.
  - tick -> START.
- START: txd=0; tick -> DATA with bit counter=0.
- DATA:
  - txd = shift-register LSB.
  - On each tick: shift right, XOR the sent bit into the parity accumulator, increment the counter.
  - When the counter equals the latched length-1 on a tick: go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - Even: txd = XOR of the data bits. Odd: its inverse.
  - tick -> STOP1.
- STOP1: txd=1; on tick go to STOP2 if the latched cfg_stop=1; otherwise go to IDLE and assert tx_done.
- STOP2: txd=1; tick -> IDLE and assert tx_done.
- tx_done:
  - High for exactly the one clk following the final stop-bit tick, coincident with the return to IDLE.
  - tx_ready is also 1 in that cycle, so back-to-back frames are accepted then.
- Frame timing, counted in ticks after accept:
  - Total ticks = 1 (SYNC) + 1 (start) + N (data bits) + P (0/1 parity) + S (1/2 stop).
  - txd changes only on the clk edge where tick=1, except for the IDLE-to-SYNC transition, which holds txd=1.
- tx_valid deasserted while tx_ready=0 is ignored; no byte is buffered beyond the one in flight.
- tick asserted in IDLE has no effect.

Test Plan:
- 8N1, tick every 4 clk, tx_data=8'hA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 (one bit per tick), then the line stays high. tx_done pulses 1 clk after the 11th tick following accept, and tx_busy is high throughout.
- 7E2, tx_data=8'hFF -> start 0, seven 1s, parity 1, stop 1, stop 1; tx_done after the 12th tick. Repeat with 7O2 -> parity bit 0.
- 5N1, tx_data=8'hE3 -> data bits 1,1,0,0,0 (bits 7:5 ignored); tx_done after the 8th tick.
- Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> second accept in the tx_done cycle; the second start bit begins one full tick period after its SYNC tick, and there is no extra idle bit.
- ubrr_in changed 12'd25->12'd103 mid-frame -> ubrr_out stays 25 until tx_done, then reads 103 on the next clk in IDLE.
- Reset pulsed while in DATA, and tick coincident with accept -> reset: txd=1, tx_ready=1, ubrr_out=0 asynchronously, no tx_done. Tick coincident with accept: SYNC waits for the following tick before the start bit.
